// File: rtl/eth_stall_watchdog.sv
// Passive AXI-Stream RX tap that fires a level trigger on link stall
// or excessive errored frames, latching the cause for software.
module eth_stall_watchdog #(
  parameter int TIMEOUT_WIDTH  = 24,
  parameter int ERR_CNT_WIDTH  = 8,
  parameter int FIRE_CNT_WIDTH = 8,
  parameter int ARM_BEATS      = 1,
  parameter bit TRIGGER_LEVEL  = 1'b0
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic                      s_tvalid,
  input  logic                      s_tready,
  input  logic                      s_tlast,
  input  logic                      s_tuser,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [TIMEOUT_WIDTH-1:0]  Timeout,
  input  logic [ERR_CNT_WIDTH-1:0]  ErrThreshold,
  output logic                      ResetTrigger,
  output logic [1:0]                state,
  output logic [1:0]                cause,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [FIRE_CNT_WIDTH-1:0] fire_count
);

  localparam int AW = (ARM_BEATS < 2) ? 1 : $clog2(ARM_BEATS + 1);

  typedef enum logic [1:0] {
    S_DIS   = 2'd0,
    S_ARM   = 2'd1,
    S_MON   = 2'd2,
    S_FIRED = 2'd3
  } st_e;

  st_e                      st_q, st_d;
  logic                     trig_q, trig_d;
  logic [1:0]               cause_q, cause_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d, err_inc;
  logic [FIRE_CNT_WIDTH-1:0] fire_q, fire_d, fire_inc;
  logic [TIMEOUT_WIDTH-1:0] idle_q, idle_d, idle_sat;
  logic [TIMEOUT_WIDTH:0]   idle_nxt;
  logic [AW-1:0]            arm_q, arm_d;
  logic                     hs, err_frame;
  logic                     to_hit, er_hit;

  assign hs        = s_tvalid & s_tready;
  assign err_frame = hs & s_tlast & s_tuser;

  assign err_inc  = (err_frame && err_q != '1) ?
                    err_q + ERR_CNT_WIDTH'(1) : err_q;
  assign fire_inc = (fire_q != '1) ?
                    fire_q + FIRE_CNT_WIDTH'(1) : fire_q;
  // one bit wider so the compare cannot wrap at all-ones
  assign idle_nxt = {1'b0, idle_q} + (TIMEOUT_WIDTH+1)'(1);
  assign idle_sat = (idle_q != '1) ?
                    idle_nxt[TIMEOUT_WIDTH-1:0] : idle_q;

  assign to_hit = (Timeout != '0) && !hs &&
                  (idle_nxt >= {1'b0, Timeout});
  assign er_hit = (ErrThreshold != '0) &&
                  (err_inc >= ErrThreshold);

  always_comb begin
    st_d    = st_q;
    trig_d  = trig_q;
    cause_d = cause_q;
    err_d   = err_q;
    fire_d  = fire_q;
    idle_d  = idle_q;
    arm_d   = arm_q;
    if (!enable || clear) begin
      st_d    = enable ? S_ARM : S_DIS;
      trig_d  = !TRIGGER_LEVEL;
      cause_d = '0;
      err_d   = '0;
      idle_d  = '0;
      arm_d   = '0;
    end else begin
      unique case (st_q)
        S_DIS: st_d = S_ARM;
        S_ARM: begin
          err_d = err_inc;
          if (hs) begin
            if (arm_q == AW'(ARM_BEATS - 1)) begin
              st_d   = S_MON;
              idle_d = '0;
              arm_d  = '0;
            end else begin
              arm_d = arm_q + AW'(1);
            end
          end
        end
        S_MON: begin
          err_d  = err_inc;
          idle_d = hs ? '0 : idle_sat;
          if (to_hit || er_hit) begin
            st_d    = S_FIRED;
            trig_d  = TRIGGER_LEVEL;
            cause_d = {er_hit, to_hit};
            fire_d  = fire_inc;
          end
        end
        S_FIRED: ;
        default: st_d = S_DIS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      st_q    <= S_DIS;
      trig_q  <= !TRIGGER_LEVEL;
      cause_q <= '0;
      err_q   <= '0;
      fire_q  <= '0;
      idle_q  <= '0;
      arm_q   <= '0;
    end else begin
      st_q    <= st_d;
      trig_q  <= trig_d;
      cause_q <= cause_d;
      err_q   <= err_d;
      fire_q  <= fire_d;
      idle_q  <= idle_d;
      arm_q   <= arm_d;
    end
  end

  assign ResetTrigger = trig_q;
  assign state        = st_q;
  assign cause        = cause_q;
  assign err_count    = err_q;
  assign fire_count   = fire_q;

endmodule
